// File: rtl/jp_pad_emu.sv
// jp_pad_emu: one NES controller (4021-style PISO shift register) driven by
// synchronised, debounced board buttons. Optional turbo on A/B is enabled by
// defining JP_PAD_TURBO_EN.
// Everything runs in the clk_in domain; jp_clk_in/jp_latch_in are expected to
// already be in that domain (they come from the rp2a03 core).

// Per-bit 2-flop synchroniser followed by a counting debouncer.
module jp_pad_db #(
   parameter int DB_CYCLES = 1_000_000,
   parameter int DB_W      = 20
) (
   input  logic clk,
   input  logic nrst,
   input  logic raw,
   output logic state
);
   logic            s1, s2;
   logic [DB_W-1:0] cnt;

   // two-flop synchroniser for the asynchronous button level
   always_ff @(posedge clk) begin
      if (!nrst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // stable level only follows the input after DB_CYCLES differing cycles in a row
   always_ff @(posedge clk) begin
      if (!nrst) begin
         cnt   <= '0;
         state <= 1'b0;
      end else if (s2 == state) begin
         cnt <= '0;
      end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
         cnt   <= '0;
         state <= s2;
      end else begin
         cnt <= cnt + DB_W'(1);
      end
   end
endmodule

module jp_pad_emu #(
   parameter int DB_CYCLES    = 1_000_000,
   parameter int DB_W         = 20,
   parameter int TURBO_FRAMES = 4
) (
   input  logic       clk_in,
   input  logic       nrst_in,
   input  logic [7:0] btn_in,
   input  logic [1:0] turbo_in,
   input  logic       jp_clk_in,
   input  logic       jp_latch_in,
   output logic       jp_data_out,
   output logic [7:0] btn_state_out
);
`ifdef JP_PAD_TURBO_EN
   localparam int NB   = 10;
   localparam int TF_W = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
`else
   localparam int NB = 8;
`endif

   logic [NB-1:0] raw;
   logic [NB-1:0] db;
   logic [7:0]    pad_vec;
   logic [7:0]    sr;
   logic          clk_prev, latch_prev;
   logic          clk_rise;

`ifdef JP_PAD_TURBO_EN
   logic            phase;
   logic [TF_W-1:0] tcnt;
   logic            latch_fall;

   assign raw        = {turbo_in, btn_in};
   assign latch_fall = ~jp_latch_in & latch_prev;
   // turbo buttons add a periodic press on top of the held A/B state
   assign pad_vec    = {db[7:2], db[1] | (db[9] & phase), db[0] | (db[8] & phase)};
`else
   logic [1:0] unused_turbo;
   localparam int tf_unused = TURBO_FRAMES;

   assign raw          = btn_in;
   assign unused_turbo = turbo_in;
   assign pad_vec      = db[7:0];
`endif

   // one synchroniser/debouncer per button (and per turbo button when enabled)
   for (genvar i = 0; i < NB; i++) begin : g_db
      jp_pad_db #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
         .clk   (clk_in),
         .nrst  (nrst_in),
         .raw   (raw[i]),
         .state (db[i])
      );
   end

   assign btn_state_out = db[7:0];
   assign clk_rise      = jp_clk_in & ~clk_prev;

   // previous-cycle copies of the strobes for edge detection
   always_ff @(posedge clk_in) begin
      if (!nrst_in) begin
         clk_prev   <= 1'b0;
         latch_prev <= 1'b0;
      end else begin
         clk_prev   <= jp_clk_in;
         latch_prev <= jp_latch_in;
      end
   end

   // shift register holds line levels (active-low); latch is a transparent
   // load and beats a coincident clock edge; zeros fill from the top so an
   // over-read reports "pressed" like the original pad
   always_ff @(posedge clk_in) begin
      if (!nrst_in)
         sr <= 8'hFF;
      else if (jp_latch_in)
         sr <= ~pad_vec;
      else if (clk_rise)
         sr <= {1'b0, sr[7:1]};
   end

   // registered serial output
   always_ff @(posedge clk_in) begin
      if (!nrst_in)
         jp_data_out <= 1'b1;
      else
         jp_data_out <= sr[0];
   end

`ifdef JP_PAD_TURBO_EN
   // turbo phase flips once every TURBO_FRAMES latch falling edges
   always_ff @(posedge clk_in) begin
      if (!nrst_in) begin
         tcnt  <= '0;
         phase <= 1'b0;
      end else if (latch_fall) begin
         if (tcnt == TF_W'(TURBO_FRAMES - 1)) begin
            tcnt  <= '0;
            phase <= ~phase;
         end else begin
            tcnt <= tcnt + TF_W'(1);
         end
      end
   end
`endif
endmodule

// File: tb/tb_jp_pad_emu.sv
// Directed bench for jp_pad_emu with DB_CYCLES=4. Turbo steps are only built
// when JP_PAD_TURBO_EN is defined.
module tb_jp_pad_emu;
   logic       clk_in = 1'b0;
   logic       nrst_in;
   logic [7:0] btn_in;
   logic [1:0] turbo_in;
   logic       jp_clk_in;
   logic       jp_latch_in;
   logic       jp_data_out;
   logic [7:0] btn_state_out;

   int vectors = 0;
   int fails   = 0;

   jp_pad_emu #(.DB_CYCLES(4), .DB_W(3), .TURBO_FRAMES(2)) dut (
      .clk_in        (clk_in),
      .nrst_in       (nrst_in),
      .btn_in        (btn_in),
      .turbo_in      (turbo_in),
      .jp_clk_in     (jp_clk_in),
      .jp_latch_in   (jp_latch_in),
      .jp_data_out   (jp_data_out),
      .btn_state_out (btn_state_out)
   );

   always #5 clk_in = ~clk_in;

   // advance one clock; inputs are changed and outputs sampled 1ns after the edge
   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // latch pulse; first bit is on the line afterwards
   task automatic do_latch();
      jp_latch_in = 1'b1;
      tick();
      jp_latch_in = 1'b0;
      tick();
   endtask

   // one jp_clk pulse; next bit is on the line afterwards
   task automatic do_shift();
      jp_clk_in = 1'b1;
      tick();
      jp_clk_in = 1'b0;
      tick();
   endtask

   logic [7:0] exp_line;

   initial begin
      nrst_in = 1'b0; btn_in = 8'h00; turbo_in = 2'b00;
      jp_clk_in = 1'b0; jp_latch_in = 1'b0;

      // T1 reset
      tick(2);
      nrst_in = 1'b1;
      chk("t1_data", {7'd0, jp_data_out}, 8'h01);
      chk("t1_state", btn_state_out, 8'h00);

      // T2 A+Start pressed, full read plus over-read
      btn_in = 8'h09;
      tick(10);
      chk("t2_state", btn_state_out, 8'h09);
      exp_line = 8'b1111_0110;
      do_latch();
      for (int b = 0; b < 8; b++) begin
         chk($sformatf("t2_bit%0d", b), {7'd0, jp_data_out}, {7'd0, exp_line[b]});
         do_shift();
      end
      chk("t2_shift8", {7'd0, jp_data_out}, 8'h00);
      do_shift();
      chk("t2_shift9", {7'd0, jp_data_out}, 8'h00);
      do_shift();
      chk("t2_shift10", {7'd0, jp_data_out}, 8'h00);

      // T3 glitch of 3 cycles is rejected, 6-cycle hold is accepted on time
      btn_in = 8'h19;
      tick(3);
      btn_in = 8'h09;
      tick(10);
      chk("t3_glitch", btn_state_out, 8'h09);
      btn_in = 8'h19;
      tick(5);
      chk("t3_early", btn_state_out, 8'h09);
      tick();
      chk("t3_ontime", btn_state_out, 8'h19);

      // T4 latch and clock rise together: load wins
      btn_in = 8'h80;
      tick(10);
      chk("t4_state", btn_state_out, 8'h80);
      jp_latch_in = 1'b1; jp_clk_in = 1'b1;
      tick();
      jp_latch_in = 1'b0; jp_clk_in = 1'b0;
      tick();
      exp_line = 8'b0111_1111;
      for (int b = 0; b < 8; b++) begin
         chk($sformatf("t4_bit%0d", b), {7'd0, jp_data_out}, {7'd0, exp_line[b]});
         do_shift();
      end

      // T5 reset in the middle of a read
      btn_in = 8'hFF;
      tick(10);
      chk("t5_state", btn_state_out, 8'hFF);
      do_latch();
      chk("t5_bit0", {7'd0, jp_data_out}, 8'h00);
      do_shift(); do_shift(); do_shift();
      chk("t5_bit3", {7'd0, jp_data_out}, 8'h00);
      nrst_in = 1'b0;
      tick();
      nrst_in = 1'b1;
      chk("t5_rst_data", {7'd0, jp_data_out}, 8'h01);
      chk("t5_rst_state", btn_state_out, 8'h00);
      do_shift();
      chk("t5_rst_shift", {7'd0, jp_data_out}, 8'h01);
      tick(10);
      chk("t5_redb", btn_state_out, 8'hFF);
      do_latch();
      chk("t5_reload_a", {7'd0, jp_data_out}, 8'h00);
      do_shift();
      chk("t5_reload_b", {7'd0, jp_data_out}, 8'h00);

`ifdef JP_PAD_TURBO_EN
      // T6 turbo A with phase flipping every 2 frames
      btn_in = 8'h00; turbo_in = 2'b01;
      nrst_in = 1'b0;
      tick();
      nrst_in = 1'b1;
      tick(10);
      exp_line = 8'b0011_0011;
      for (int f = 0; f < 8; f++) begin
         do_latch();
         chk($sformatf("t6_frame%0d", f), {7'd0, jp_data_out}, {7'd0, exp_line[f]});
         tick(2);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
